// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between the hazard/flush controller and the datapath stages.
// The slave modport is the controller side; master is the datapath/test side.
interface pipe_ctrl_if;
   // Level-qualified, no handshake: the datapath presents jump/hazard/busy status every
   // cycle and the controller answers combinationally in that same cycle; no ready path.
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic [4:0]  id_rs1_addr_i;
   logic [4:0]  id_rs2_addr_i;
   logic [4:0]  ex_rd_addr_i;
   logic        ex_mem_rd_i;
   logic        ex_busy_i;
   logic        jump_en_o;
   logic [31:0] jump_addr_o;
   logic        hold_flag_o;
   logic        stall_o;
   logic        ex_stall_o;
   logic [1:0]  state_o;
   logic [31:0] stall_cnt_o;
   logic [31:0] flush_cnt_o;

   modport slave (
      input  jump_en_i, jump_addr_i, id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i,
             ex_mem_rd_i, ex_busy_i,
      output jump_en_o, jump_addr_o, hold_flag_o, stall_o, ex_stall_o, state_o,
             stall_cnt_o, flush_cnt_o
   );

   modport master (
      output jump_en_i, jump_addr_i, id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i,
             ex_mem_rd_i, ex_busy_i,
      input  jump_en_o, jump_addr_o, hold_flag_o, stall_o, ex_stall_o, state_o,
             stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: busy stalls, jump flushes and load-use bubbles.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
   parameter int unsigned LOAD_STALL_CYC = 1
) (
   input logic        clk,
   input logic        rst,
   pipe_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      FLUSH      = 2'd1,
      LOAD_STALL = 2'd2,
      BUSY_STALL = 2'd3
   } state_e;

   localparam logic [2:0] CNT_RELOAD = 3'(LOAD_STALL_CYC - 1);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        hazard;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        hold;
   logic        stall;
   logic        ex_stall;

   always_comb begin
      hazard    = bus.ex_mem_rd_i && (bus.ex_rd_addr_i != 5'd0) &&
                  ((bus.ex_rd_addr_i == bus.id_rs1_addr_i) ||
                   (bus.ex_rd_addr_i == bus.id_rs2_addr_i));
      state_d   = IDLE;
      cnt_d     = 3'd0;
      jump_en   = 1'b0;
      jump_addr = 32'd0;
      hold      = 1'b0;
      stall     = 1'b0;
      ex_stall  = 1'b0;

      // Busy beats everything: a jump resolved under a frozen ex is not real yet.
      if (bus.ex_busy_i) begin
         stall    = 1'b1;
         ex_stall = 1'b1;
         state_d  = BUSY_STALL;
      end else if (bus.jump_en_i) begin
         jump_en   = 1'b1;
         jump_addr = bus.jump_addr_i;
         hold      = 1'b1;
         state_d   = FLUSH;
      end else begin
         case (state_q)
            LOAD_STALL: begin
               stall = 1'b1;
               hold  = 1'b1;
               if (cnt_q > 3'd1) begin
                  cnt_d   = cnt_q - 3'd1;
                  state_d = LOAD_STALL;
               end
            end
            FLUSH: begin
               hold = 1'b1;
            end
            IDLE: begin
               if (hazard) begin
                  stall = 1'b1;
                  hold  = 1'b1;
                  cnt_d = CNT_RELOAD;
                  if (LOAD_STALL_CYC > 1) state_d = LOAD_STALL;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are combinational, so they are gated to keep them quiet during reset.
   assign bus.jump_en_o   = rst & jump_en;
   assign bus.jump_addr_o = rst ? jump_addr : 32'd0;
   assign bus.hold_flag_o = rst & hold;
   assign bus.stall_o     = rst & stall;
   assign bus.ex_stall_o  = rst & ex_stall;
   assign bus.state_o     = state_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (jump_en && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= 32'd0;
         flush_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall_cnt_o = stall_cnt_q;
   assign bus.flush_cnt_o = flush_cnt_q;
`else
   assign bus.stall_cnt_o = 32'd0;
   assign bus.flush_cnt_o = 32'd0;
`endif

endmodule
